frame_bram_scheduler: RTL and testbench
=======================================

Name: frame_bram_scheduler

Overview:
- Time-shares the single-port 64K x 8 image BRAM between the VGA display read path and a pixel-loader write stream.
- Display reads have absolute priority inside the 256x256 image window.
- Loader writes use a valid/ready handshake and are granted on all other cycles.
- Also latches the brightness-mode select once per frame, so the mode never changes mid-image.

Parameters:
- H_BP, 144, first horizontal counter value of the image window
- V_BP, 31, first vertical counter value of the image window
- W, 256, image width in pixels
- H, 256, image height in lines
- ADDR_W, 16, BRAM address width
- DATA_W, 8, BRAM data width (RGB 3-3-2)

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  synchronous active-low reset
- output_signal  in  1  video active from VGA timing
- horizontal_counter  in  10  VGA horizontal count
- vertical_counter  in  10  VGA vertical count
- switch_sel  in  2  requested brightness mode
- wr_valid  in  1  loader write request
- wr_addr  in  ADDR_W  loader write address
- wr_data  in  DATA_W  loader write data
- wr_ready  out  1  write accepted this cycle
- ram_addr  out  ADDR_W  registered BRAM address
- ram_we  out  1  registered BRAM write enable
- ram_wdata  out  DATA_W  registered BRAM write data
- pix_valid  out  1  BRAM read data valid for display this cycle
- mode_q  out  2  frame-latched brightness mode
- frame_cnt  out  8  frames started since reset, wraps
- wr_stall_cnt  out  16  cycles with wr_valid=1 and wr_ready=0, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs are 0. State is IDLE. wr_ready is forced to 0 while rst_n=0.
- rd_req (combinational):
  - Asserted when output_signal=1 and H_BP <= horizontal_counter < H_BP+W and V_BP <= vertical_counter < V_BP+H.
  - Comparisons are unsigned 10-bit.
- Read address: {(horizontal_counter-H_BP)[7:0], (vertical_counter-V_BP)[7:0]}. Column is in the high byte.
- frame_start: asserted when horizontal_counter==0 and vertical_counter==0.
- States:
  - IDLE: entered at reset. Left on the first frame_start: to READ if rd_req, otherwise BLANK. No reads are issued in IDLE; writes are granted.
  - READ: rd_req=1. Register ram_addr=read address, ram_we=0.
  - BLANK: rd_req=0. Writes are granted.
  - READ<->BLANK transitions follow rd_req every cycle.
- wr_ready = rst_n and not rd_req (and see the optional feature).
- Write accept: wr_valid and wr_ready at edge N. At edge N+1: ram_addr=wr_addr, ram_wdata=wr_data, ram_we=1 for exactly one cycle. Back-to-back accepts give back-to-back writes.
- Collision (rd_req and wr_valid in the same cycle): the read wins, wr_ready=0, and the loader must hold addr/data stable. wr_stall_cnt +1, saturating at 0xFFFF.
- Idle bus: with no read and no accepted write, ram_we=0 and ram_addr holds its last value.
- pix_valid: rd_req delayed 2 cycles (address register + BRAM output register).
- mode_q: loads switch_sel only on a frame_start cycle. It is stable for the whole frame, including IDLE exit.
- frame_cnt: +1 on every frame_start, wraps 255->0.
- Reset mid-frame: the in-flight write is dropped (ram_we=0 next cycle), pix_valid pipeline cleared, state returns to IDLE and waits for the next frame_start.

Optional Feature:
FRAME_WR_LOCK_EN
- Defined: wr_ready additionally requires vertical_counter outside [V_BP, V_BP+H). Loader writes happen only during vertical blanking, so no tearing. wr_stall_cnt counts these stalls as well.
- Undefined: writes are granted on any non-read cycle, including horizontal blanking.

Test Plan:
- Reset: rst_n=0 for 3 cycles with wr_valid=1 -> wr_ready=0, ram_we=0, all outputs 0, state IDLE.
- Read path: counters h=144, v=31, output_signal=1 -> ram_addr=0x0000 next cycle, pix_valid=1 two cycles after.
- Read path, window corner: h=399, v=286 -> ram_addr=0xFFFF; at h=400, rd_req=0.
- Collision: wr_valid=1, wr_addr=0x1234, wr_data=0xA5 held through 10 in-window cycles -> wr_ready=0 and wr_stall_cnt=10. At h=400, accept; next cycle ram_we=1, ram_addr=0x1234, ram_wdata=0xA5.
- Mode latch: switch_sel changes 0->2 mid-frame -> mode_q stays 0 until h=0,v=0, then mode_q=2; frame_cnt increments by 1.
- FRAME_WR_LOCK_EN defined: wr_valid during h=50, v=100 -> wr_ready=0. At v=300 -> wr_ready=1 and the write is issued.

Source files
------------

// File: rtl/frame_bram_if.sv
// Loader write handshake and registered BRAM port shared between the pixel
// loader (master) and frame_bram_scheduler (slave).
interface frame_bram_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/frame_bram_scheduler.sv
// Time-shares the single-port image BRAM between display reads and loader writes.
// Optional FRAME_WR_LOCK_EN restricts loader writes to vertical blanking.
module frame_bram_scheduler #(
    parameter int H_BP   = 144,
    parameter int V_BP   = 31,
    parameter int W      = 256,
    parameter int H      = 256,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              output_signal_i,
    input  logic [9:0]        horizontal_counter_i,
    input  logic [9:0]        vertical_counter_i,
    input  logic [1:0]        switch_sel_i,
    frame_bram_if.slave       bus,
    output logic              pix_valid_o,
    output logic [1:0]        mode_q_o,
    output logic [7:0]        frame_cnt_o,
    output logic [15:0]       wr_stall_cnt_o
);
    localparam logic [9:0] H_LO  = 10'(H_BP);
    localparam logic [9:0] H_HI  = 10'(H_BP + W);
    localparam logic [9:0] V_LO  = 10'(V_BP);
    localparam logic [9:0] V_HI  = 10'(V_BP + H);
    localparam logic [7:0] H_LO8 = 8'(H_BP);
    localparam logic [7:0] V_LO8 = 8'(V_BP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              pix_p1_q, pix_p1_d;
    logic              pix_valid_q, pix_valid_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic              h_in_s, v_in_s, rd_req_s, rd_issue_s;
    logic              frame_start_s, wr_ready_s, wr_fire_s;
    logic [7:0]        col_s, row_s;
    logic [ADDR_W-1:0] rd_addr_s;

    assign h_in_s        = (horizontal_counter_i >= H_LO) && (horizontal_counter_i < H_HI);
    assign v_in_s        = (vertical_counter_i >= V_LO) && (vertical_counter_i < V_HI);
    assign rd_req_s      = output_signal_i && h_in_s && v_in_s;
    assign frame_start_s = (horizontal_counter_i == 10'd0) && (vertical_counter_i == 10'd0);

    // Low byte of the difference depends only on the low bytes of the operands.
    assign col_s     = horizontal_counter_i[7:0] - H_LO8;
    assign row_s     = vertical_counter_i[7:0] - V_LO8;
    assign rd_addr_s = ADDR_W'({col_s, row_s});

    // Reads are only issued once the first frame boundary has been seen.
    assign rd_issue_s = rd_req_s && (state_q != IDLE);

`ifdef FRAME_WR_LOCK_EN
    assign wr_ready_s = rst_n && !rd_req_s && !v_in_s;
`else
    assign wr_ready_s = rst_n && !rd_req_s;
`endif
    assign wr_fire_s    = bus.wr_valid && wr_ready_s;
    assign bus.wr_ready = wr_ready_s;

    // Next-state logic for the scheduler phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_start_s) begin
                    state_d = rd_req_s ? READ : BLANK;
                end else begin
                    state_d = IDLE;
                end
            end
            READ:    state_d = rd_req_s ? READ : BLANK;
            BLANK:   state_d = rd_req_s ? READ : BLANK;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the BRAM port, display pipeline and frame bookkeeping.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (rd_issue_s) begin
            ram_addr_d = rd_addr_s;
        end else if (wr_fire_s) begin
            ram_addr_d  = bus.wr_addr;
            ram_wdata_d = bus.wr_data;
            ram_we_d    = 1'b1;
        end else begin
            ram_we_d = 1'b0;
        end

        pix_p1_d    = rd_issue_s;
        pix_valid_d = pix_p1_q;

        if (frame_start_s) begin
            mode_d      = switch_sel_i;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            mode_d      = mode_q;
            frame_cnt_d = frame_cnt_q;
        end

        if (bus.wr_valid && !wr_ready_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            pix_p1_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            mode_q      <= 2'd0;
            frame_cnt_q <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            pix_p1_q    <= pix_p1_d;
            pix_valid_q <= pix_valid_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign pix_valid_o    = pix_valid_q;
    assign mode_q_o       = mode_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign wr_stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_frame_bram_scheduler.sv
// Scoreboard bench for frame_bram_scheduler: stimulus pushes expected BRAM
// writes and display reads; a negedge monitor pops and compares them.
module tb_frame_bram_scheduler;
`ifdef FRAME_WR_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        output_signal;
    logic [9:0]  hc, vc;
    logic [1:0]  switch_sel;
    logic        pix_valid;
    logic [1:0]  mode_q;
    logic [7:0]  frame_cnt;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int rel_v;
    wr_t         wr_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] prev_addr = 16'd0;

    frame_bram_if #(.ADDR_W(16), .DATA_W(8)) bif ();

    frame_bram_scheduler dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .output_signal_i      (output_signal),
        .horizontal_counter_i (hc),
        .vertical_counter_i   (vc),
        .switch_sel_i         (switch_sel),
        .bus                  (bif.slave),
        .pix_valid_o          (pix_valid),
        .mode_q_o             (mode_q),
        .frame_cnt_o          (frame_cnt),
        .wr_stall_cnt_o       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t t;
        t.addr = a;
        t.data = d;
        wr_q.push_back(t);
    endtask

    // Monitor: every presented write or display pixel must match the scoreboard.
    initial begin
        wr_t t;
        logic [15:0] ra;
        forever begin
            @(negedge clk);
            if (bif.ram_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(bif.ram_addr), 32'hFFFF_FFFF);
                end else begin
                    t = wr_q.pop_front();
                    check("wr_addr", 32'(bif.ram_addr), 32'(t.addr));
                    check("wr_data", 32'(bif.ram_wdata), 32'(t.data));
                end
            end
            if (pix_valid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_pix", 32'(prev_addr), 32'hFFFF_FFFF);
                end else begin
                    ra = rd_q.pop_front();
                    check("rd_addr", 32'(prev_addr), 32'(ra));
                end
            end
            prev_addr = bif.ram_addr;
        end
    end

    initial begin
        rel_v = LOCK_EN ? 300 : 100;

        // Reset with a pending write request
        rst_n = 1'b0; output_signal = 1'b1; hc = 10'd0; vc = 10'd0; switch_sel = 2'd1;
        bif.wr_valid = 1'b1; bif.wr_addr = 16'h5555; bif.wr_data = 8'hFF;
        #1;
        check("rst_wr_ready", 32'(bif.wr_ready), 32'd0);
        repeat (3) cyc();
        check("rst_wr_ready2", 32'(bif.wr_ready), 32'd0);
        check("rst_ram_we", 32'(bif.ram_we), 32'd0);
        check("rst_ram_addr", 32'(bif.ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(bif.ram_wdata), 32'd0);
        check("rst_pix", 32'(pix_valid), 32'd0);
        check("rst_mode", 32'(mode_q), 32'd0);
        check("rst_frame", 32'(frame_cnt), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);

        // IDLE: in-window counters must not issue reads before a frame start
        rst_n = 1'b1; bif.wr_valid = 1'b0; hc = 10'd150; vc = 10'd40;
        repeat (2) cyc();
        check("idle_addr", 32'(bif.ram_addr), 32'd0);
        check("idle_frame", 32'(frame_cnt), 32'd0);

        hc = 10'd0; vc = 10'd0; switch_sel = 2'd0;
        cyc();
        check("fs1_frame", 32'(frame_cnt), 32'd1);
        check("fs1_mode", 32'(mode_q), 32'd0);

        // Read path and window corner
        hc = 10'd144; vc = 10'd31; rd_q.push_back(16'h0000);
        cyc();
        check("rd0_addr", 32'(bif.ram_addr), 32'h0000);
        check("rd0_we", 32'(bif.ram_we), 32'd0);
        hc = 10'd145; rd_q.push_back(16'h0100);
        cyc();
        hc = 10'd399; vc = 10'd286; rd_q.push_back(16'hFFFF);
        cyc();
        check("corner_addr", 32'(bif.ram_addr), 32'hFFFF);
        hc = 10'd400;
        cyc();
        check("h400_wr_ready", 32'(bif.wr_ready), LOCK_EN ? 32'd0 : 32'd1);
        check("idle_bus_addr", 32'(bif.ram_addr), 32'hFFFF);
        check("idle_bus_we", 32'(bif.ram_we), 32'd0);

        // Mode request changes mid-frame; collision for 10 in-window cycles
        switch_sel = 2'd2;
        bif.wr_valid = 1'b1; bif.wr_addr = 16'h1234; bif.wr_data = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            hc = 10'(200 + i); vc = 10'd100;
            rd_q.push_back({8'(56 + i), 8'h45});
            cyc();
            check("coll_wr_ready", 32'(bif.wr_ready), 32'd0);
        end
        check("coll_stall", 32'(stall_cnt), 32'd10);
        check("mid_mode", 32'(mode_q), 32'd0);

        hc = 10'd400; vc = 10'(rel_v); push_wr(16'h1234, 8'hA5);
        cyc();
        check("rel_wr_ready", 32'(bif.wr_ready), 32'd1);
        check("rel_stall", 32'(stall_cnt), 32'd10);
        bif.wr_valid = 1'b0; hc = 10'd401;
        cyc();
        check("rel_we_drop", 32'(bif.ram_we), 32'd0);

        // Back-to-back writes
        bif.wr_valid = 1'b1; hc = 10'd410;
        bif.wr_addr = 16'h0001; bif.wr_data = 8'h11; push_wr(16'h0001, 8'h11);
        cyc();
        bif.wr_addr = 16'h0002; bif.wr_data = 8'h22; push_wr(16'h0002, 8'h22);
        cyc();
        bif.wr_valid = 1'b0;
        cyc();
        check("b2b_we_drop", 32'(bif.ram_we), 32'd0);

        // Horizontal blanking inside the image rows, then vertical blanking
        hc = 10'd50; vc = 10'd100; bif.wr_valid = 1'b1;
        bif.wr_addr = 16'h0050; bif.wr_data = 8'h77;
        if (!LOCK_EN) push_wr(16'h0050, 8'h77);
        cyc();
        check("hblank_wr_ready", 32'(bif.wr_ready), LOCK_EN ? 32'd0 : 32'd1);
        vc = 10'd300; bif.wr_addr = 16'h0051; bif.wr_data = 8'h78; push_wr(16'h0051, 8'h78);
        cyc();
        check("vblank_wr_ready", 32'(bif.wr_ready), 32'd1);
        bif.wr_valid = 1'b0;
        cyc();
        check("stall_total", 32'(stall_cnt), LOCK_EN ? 32'd11 : 32'd10);

        // Frame start latches the new mode; then frame counter wraps
        hc = 10'd0; vc = 10'd0;
        cyc();
        check("fs2_mode", 32'(mode_q), 32'd2);
        check("fs2_frame", 32'(frame_cnt), 32'd2);
        repeat (254) cyc();
        check("frame_wrap", 32'(frame_cnt), 32'd0);
        hc = 10'd1; switch_sel = 2'd3;
        cyc();
        check("mode_hold", 32'(mode_q), 32'd2);

        // Write presented, read in flight, then reset mid-frame
        hc = 10'd420; vc = 10'(rel_v); bif.wr_valid = 1'b1;
        bif.wr_addr = 16'hBEEF; bif.wr_data = 8'h5A; push_wr(16'hBEEF, 8'h5A);
        cyc();
        bif.wr_valid = 1'b0; hc = 10'd200; vc = 10'd100;
        cyc();
        check("inflight_addr", 32'(bif.ram_addr), 32'h3845);
        rst_n = 1'b0;
        cyc();
        check("mrst_we", 32'(bif.ram_we), 32'd0);
        check("mrst_addr", 32'(bif.ram_addr), 32'd0);
        check("mrst_pix", 32'(pix_valid), 32'd0);
        check("mrst_frame", 32'(frame_cnt), 32'd0);
        check("mrst_stall", 32'(stall_cnt), 32'd0);
        cyc();
        rst_n = 1'b1; hc = 10'd150; vc = 10'd40;
        repeat (3) cyc();
        check("post_rst_addr", 32'(bif.ram_addr), 32'd0);
        check("post_rst_pix", 32'(pix_valid), 32'd0);

        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
